// File: rtl/pipe_pkg.sv
// Shared control-word definitions for the pipelined core.
// The control pipeline itself is width-generic; these types pin the core's layout.
package pipe_pkg;

    localparam int CTRL_W = 14;

    typedef struct packed {
        logic       RegWrite;
        logic [1:0] ResultSrc;
        logic       MemWrite;
        logic [4:0] ALUControl;
        logic [1:0] ALUSrc_A;
        logic       ALUSrc_B;
        logic [1:0] PCSrc;
    } ctrl_t;

    // All-zero word: RegWrite and MemWrite deasserted, so a bubble is harmless.
    localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/pipe_reg.sv
// One control pipeline stage: a valid bit plus a control word.
// Priority is reset, then bubble, then hold, then load.
module pipe_reg #(
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bubble_i,
    input  logic             hold_i,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] ctrl_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] ctrl_o
);

    logic             vld_q, vld_d;
    logic [WIDTH-1:0] ctrl_q, ctrl_d;

    always_comb begin
        vld_d  = vld_q;
        ctrl_d = ctrl_q;
        if (bubble_i) begin
            vld_d  = 1'b0;
            ctrl_d = '0;
        end else if (!hold_i) begin
            vld_d  = vld_i;
            ctrl_d = ctrl_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            ctrl_q <= '0;
        end else begin
            vld_q  <= vld_d;
            ctrl_q <= ctrl_d;
        end
    end

    assign vld_o  = vld_q;
    assign ctrl_o = ctrl_q;

endmodule

// File: rtl/ctrl_pipe.sv
// Generic control-signal pipeline: NSTAGE stages with per-stage flush,
// load-use bubble insertion and a counter-driven multi-cycle hold of stage 0.
module ctrl_pipe
    import pipe_pkg::*;
#(
    parameter int NSTAGE = 3,
    parameter int WIDTH  = CTRL_W,
    parameter int LATW   = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [WIDTH-1:0]        in_ctrl,
    input  logic                    stall_d,
    input  logic [NSTAGE-1:0]       flush,
    input  logic                    mc_start,
    input  logic [LATW-1:0]         mc_lat,
    output logic                    in_ready,
    output logic                    busy,
    output logic [NSTAGE-1:0]       stg_valid,
    output logic [NSTAGE*WIDTH-1:0] stg_ctrl
);

    logic [LATW-1:0]              cnt_q, cnt_d;
    logic [NSTAGE-1:0]            bub, hold, vld_in, vld_out;
    logic [NSTAGE-1:0][WIDTH-1:0] ctrl_in, ctrl_out;
    logic                         load0;

    assign busy     = (cnt_q != '0);
    assign in_ready = !rst && !busy && !stall_d;
    assign load0    = !flush[0] && !busy && !stall_d;

    always_comb begin
        bub        = '0;
        hold       = '0;
        vld_in     = '0;
        ctrl_in    = '0;
        // Stall only bubbles stage 0 when no hold is active; the hold wins.
        bub[0]     = flush[0] || (!busy && stall_d);
        hold[0]    = busy;
        vld_in[0]  = in_valid;
        ctrl_in[0] = in_valid ? in_ctrl : '0;
        for (int i = 1; i < NSTAGE; i++) begin
            bub[i]     = flush[i] || ((i == 1) && busy);
            vld_in[i]  = vld_out[i-1];
            ctrl_in[i] = ctrl_out[i-1];
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (flush[0]) begin
            cnt_d = '0;
        end else if (busy) begin
            cnt_d = cnt_q - LATW'(1);
        end else if (load0 && in_valid && mc_start) begin
            cnt_d = mc_lat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    for (genvar g = 0; g < NSTAGE; g++) begin : g_stage
        pipe_reg #(
            .WIDTH (WIDTH)
        ) u_reg (
            .clk      (clk),
            .rst      (rst),
            .bubble_i (bub[g]),
            .hold_i   (hold[g]),
            .vld_i    (vld_in[g]),
            .ctrl_i   (ctrl_in[g]),
            .vld_o    (vld_out[g]),
            .ctrl_o   (ctrl_out[g])
        );
    end

    assign stg_valid = vld_out;
    assign stg_ctrl  = ctrl_out;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: a per-edge behavioural model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_ctrl_pipe;

    localparam int NS = 3;
    localparam int W  = 14;
    localparam int LW = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [W-1:0]      in_ctrl = '0;
    logic              stall_d = 1'b0;
    logic [NS-1:0]     flush = '0;
    logic              mc_start = 1'b0;
    logic [LW-1:0]     mc_lat = '0;
    logic              in_ready, busy;
    logic [NS-1:0]     stg_valid;
    logic [NS*W-1:0]   stg_ctrl;

    int errs   = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model state: what each stage holds and how many hold cycles remain.
    bit           m_v [NS];
    logic [W-1:0] m_c [NS];
    int           m_rem = 0;

    ctrl_pipe #(.NSTAGE(NS), .WIDTH(W), .LATW(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ctrl   (in_ctrl),
        .stall_d   (stall_d),
        .flush     (flush),
        .mc_start  (mc_start),
        .mc_lat    (mc_lat),
        .in_ready  (in_ready),
        .busy      (busy),
        .stg_valid (stg_valid),
        .stg_ctrl  (stg_ctrl)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] sc(input int i);
        return stg_ctrl[i*W +: W];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: stages shift toward writeback unless killed; stage 0
    // is frozen while an op still owes extra cycles.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NS; i++) begin
                m_v[i] = 1'b0;
                m_c[i] = '0;
            end
            m_rem = 0;
        end else begin
            bit hold_now;
            hold_now = (m_rem > 0);
            for (int i = NS - 1; i >= 1; i--) begin
                if (flush[i] || (i == 1 && hold_now)) begin
                    m_v[i] = 1'b0;
                    m_c[i] = '0;
                end else begin
                    m_v[i] = m_v[i-1];
                    m_c[i] = m_c[i-1];
                end
            end
            if (flush[0]) begin
                m_v[0] = 1'b0;
                m_c[0] = '0;
                m_rem  = 0;
            end else if (hold_now) begin
                m_rem = m_rem - 1;
            end else if (stall_d || !in_valid) begin
                m_v[0] = 1'b0;
                m_c[0] = '0;
            end else begin
                m_v[0] = 1'b1;
                m_c[0] = in_ctrl;
                m_rem  = mc_start ? int'(mc_lat) : 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NS; i++) begin
                chk($sformatf("model valid[%0d]", i), 32'(stg_valid[i]), 32'(m_v[i]));
                chk($sformatf("model ctrl[%0d]", i), 32'(sc(i)), 32'(m_c[i]));
            end
            chk("model busy", 32'(busy), 32'(m_rem > 0));
            chk("model in_ready", 32'(in_ready), 32'(!rst && m_rem == 0 && !stall_d));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] c, input logic st,
                         input logic [NS-1:0] fl, input logic mcs, input logic [LW-1:0] lat);
        in_valid = v;
        in_ctrl  = c;
        stall_d  = st;
        flush    = fl;
        mc_start = mcs;
        mc_lat   = lat;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    initial begin
        // Reset with a live, all-ones word presented.
        rst = 1'b1;
        drive(1'b1, 14'h3FFF, 1'b0, '0, 1'b0, '0);
        step();
        chk_en = 1'b1;
        step();
        chk("rst valid", 32'(stg_valid), 32'h0);
        chk("rst ctrl", 32'(stg_ctrl), 32'h0);
        chk("rst in_ready", 32'(in_ready), 32'h0);
        chk("rst busy", 32'(busy), 32'h0);
        rst = 1'b0;
        idle();
        #1;
        chk("post-rst in_ready", 32'(in_ready), 32'h1);

        // Stream three words back to back.
        drive(1'b1, 14'h0001, 1'b0, '0, 1'b0, '0);
        step();
        drive(1'b1, 14'h0002, 1'b0, '0, 1'b0, '0);
        step();
        drive(1'b1, 14'h0003, 1'b0, '0, 1'b0, '0);
        step();
        chk("stream s2 t+2", 32'(sc(2)), 32'h1);
        chk("stream valid all", 32'(stg_valid), 32'h7);
        idle();
        step();
        chk("stream s2 t+3", 32'(sc(2)), 32'h2);
        step();
        chk("stream s2 t+4", 32'(sc(2)), 32'h3);

        // Load-use stall behind 0x11.
        drive(1'b1, 14'h0011, 1'b0, '0, 1'b0, '0);
        step();
        drive(1'b1, 14'h0012, 1'b1, '0, 1'b0, '0);
        #1;
        chk("stall in_ready", 32'(in_ready), 32'h0);
        step();
        chk("stall s0 bubble", 32'(stg_valid[0]), 32'h0);
        chk("stall s1 advances", 32'(sc(1)), 32'h11);
        drive(1'b1, 14'h0012, 1'b0, '0, 1'b0, '0);
        step();
        chk("stall s0 loads", 32'(sc(0)), 32'h12);
        chk("stall s2 advances", 32'(sc(2)), 32'h11);

        // Multi-cycle op, latency 3; upstream keeps offering 0x22.
        drive(1'b1, 14'h0021, 1'b0, '0, 1'b1, 5'd3);
        step();
        drive(1'b1, 14'h0022, 1'b0, '0, 1'b0, '0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("mc busy", 32'(busy), 32'h1);
            chk("mc in_ready", 32'(in_ready), 32'h0);
            chk("mc s0 held", 32'(sc(0)), 32'h21);
            step();
            chk("mc s1 bubble", 32'(stg_valid[1]), 32'h0);
        end
        chk("mc busy done", 32'(busy), 32'h0);
        chk("mc s0 4th cycle", 32'(sc(0)), 32'h21);
        step();
        chk("mc s1 gets op", 32'(sc(1)), 32'h21);
        chk("mc s0 next op", 32'(sc(0)), 32'h22);
        idle();
        step();

        // Stall arriving during a hold must not bubble the op.
        drive(1'b1, 14'h0031, 1'b0, '0, 1'b1, 5'd2);
        step();
        drive(1'b0, '0, 1'b1, '0, 1'b0, '0);
        step();
        chk("coll stall s0 held", 32'(sc(0)), 32'h31);
        chk("coll stall s0 valid", 32'(stg_valid[0]), 32'h1);
        idle();
        step();
        step();
        chk("coll stall op lands", 32'(sc(1)), 32'h31);

        // Single-cycle behaviour for mc_lat = 0.
        drive(1'b1, 14'h0071, 1'b0, '0, 1'b1, 5'd0);
        step();
        idle();
        chk("lat0 busy", 32'(busy), 32'h0);
        step();
        chk("lat0 s1", 32'(sc(1)), 32'h71);

        // Flush stages 0 and 1 while holding A, B, C.
        drive(1'b1, 14'h0041, 1'b0, '0, 1'b0, '0);
        step();
        drive(1'b1, 14'h0042, 1'b0, '0, 1'b0, '0);
        step();
        drive(1'b1, 14'h0043, 1'b0, '0, 1'b0, '0);
        step();
        drive(1'b0, '0, 1'b0, 3'b011, 1'b0, '0);
        step();
        chk("flush valid", 32'(stg_valid), 32'h4);
        chk("flush s2", 32'(sc(2)), 32'h42);
        idle();
        step();

        // flush[0] at cnt=2 aborts the op.
        drive(1'b1, 14'h0051, 1'b0, '0, 1'b1, 5'd3);
        step();
        idle();
        step();
        drive(1'b0, '0, 1'b0, 3'b001, 1'b0, '0);
        step();
        chk("abort busy", 32'(busy), 32'h0);
        chk("abort s0/s1", 32'(stg_valid[1:0]), 32'h0);
        idle();
        step();
        step();
        chk("abort nothing arrives", 32'(stg_valid), 32'h0);

        // Reset in the middle of a hold.
        drive(1'b1, 14'h0061, 1'b0, '0, 1'b1, 5'd3);
        step();
        idle();
        step();
        rst = 1'b1;
        step();
        chk("rst-hold busy", 32'(busy), 32'h0);
        chk("rst-hold valid", 32'(stg_valid), 32'h0);
        rst = 1'b0;
        #1;
        chk("rst-hold in_ready", 32'(in_ready), 32'h1);
        step();
        step();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
